instr_fetch_unit: RTL

- Fetch stage directly upstream of the instruction decoder/control unit in the reduced RISC-V core.
- Holds the PC, requests instructions from a synchronous instruction memory over a req/gnt/rvalid handshake, and presents one instruction at a time to decode with a valid/ready handshake.
- Consumes the branch decision (PCsrc) and sign-extended offset (ImmOp) that decode/extend produce for the presented instruction, and computes the next PC from them.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/pc_next.sv | 25 ++
 rtl/instr_fetch_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_state_t   : fetch FSM state encoding
//   PC_STEP_DEFAULT : sequential PC increment in bytes
//   INSTR_NOP       : canonical RISC-V NOP (addi x0, x0, 0)
package fetch_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      VALID,
      HALT
   } fetch_state_t;

   localparam int          PC_STEP_DEFAULT = 4;
   localparam logic [31:0] INSTR_NOP       = 32'h0000_0013;

endpackage

// File: rtl/pc_next.sv
// pc_next: next-PC adder and misalignment detect for the fetch stage.
//   pc         : address of the instruction being accepted
//   pcsrc      : branch taken
//   imm        : sign-extended branch offset
//   next_pc    : pcsrc ? pc + imm : pc + PC_STEP (modular, carry dropped)
//   misaligned : next_pc is not word aligned
module pc_next
   import fetch_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int PC_STEP    = PC_STEP_DEFAULT
) (
   input  logic [ADDR_WIDTH-1:0] pc,
   input  logic                  pcsrc,
   input  logic [ADDR_WIDTH-1:0] imm,
   output logic [ADDR_WIDTH-1:0] next_pc,
   output logic                  misaligned
);

   always_comb begin
      next_pc    = pc + (pcsrc ? imm : ADDR_WIDTH'(PC_STEP));
      misaligned = |next_pc[1:0];
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC register plus fetch FSM between instruction memory and decode.
//   clk, rst_n                : clock, async active-low reset
//   imem_req/addr/gnt/rvalid/rdata : single-outstanding memory handshake
//   instr, instr_valid, instr_ready : instruction handoff to decode
//   PCsrc, ImmOp              : branch decision/offset, sampled on accept
//   PC                        : address of presented/in-flight instruction
//   fetch_err                 : sticky misaligned-PC error (stage halts)
//   fetch_count               : accepted instruction count, wraps
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    PC_STEP    = PC_STEP_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_gnt,
   input  logic                  imem_rvalid,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic [DATA_WIDTH-1:0] instr,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   input  logic                  PCsrc,
   input  logic [ADDR_WIDTH-1:0] ImmOp,
   output logic [ADDR_WIDTH-1:0] PC,
   output logic                  fetch_err,
   output logic [31:0]           fetch_count
);

   fetch_state_t          state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0] instr_q, instr_d;
   logic                  req_q, req_d;
   logic                  valid_q, valid_d;
   logic                  err_q, err_d;
   logic [31:0]           count_q, count_d;
   logic [ADDR_WIDTH-1:0] next_pc;
   logic                  misaligned;

   pc_next #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .PC_STEP   (PC_STEP)
   ) u_pc_next (
      .pc        (pc_q),
      .pcsrc     (PCsrc),
      .imm       (ImmOp),
      .next_pc   (next_pc),
      .misaligned(misaligned)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      err_d   = err_q;
      count_d = count_q;
      case (state_q)
         IDLE: begin
            // A misaligned reset vector can never fetch, so halt straight away.
            if (|RESET_PC[1:0]) begin
               err_d   = 1'b1;
               state_d = HALT;
            end else begin
               state_d = REQ;
            end
         end
         REQ:  state_d = imem_gnt ? WAIT : REQ;
         WAIT: begin
            if (imem_rvalid) begin
               instr_d = imem_rdata;
               state_d = VALID;
            end
         end
         VALID: begin
            if (instr_ready) begin
               count_d = count_q + 32'd1;
               if (misaligned) begin
                  // PC stays on the offending instruction for debug.
                  err_d   = 1'b1;
                  state_d = HALT;
               end else begin
                  pc_d    = next_pc;
                  state_d = REQ;
               end
            end
         end
         HALT:    err_d   = 1'b1;
         default: state_d = HALT;
      endcase
      // Outputs are registered: decode them from the next state.
      req_d   = (state_d == REQ);
      valid_d = (state_d == VALID);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         req_q   <= req_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         count_q <= count_d;
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign PC          = pc_q;
   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign fetch_err   = err_q;
   assign fetch_count = count_q;

endmodule
